// File: rtl/vga_timing_core.sv
// vga_timing_core
//   Parametrised VGA timing generator and pixel-output stage. Produces the
//   h/v counters (exported as xcoor/ycoor), line/frame start strobes, sync and
//   blanking, and aligns pixel data returned by a generator of latency PIPE.
//
// Ports
//   clk            pixel clock
//   rst            synchronous active-high reset
//   enable         advance counters, delay line and outputs this cycle
//   red_in/green_in/blue_in   pixel for the coordinate issued PIPE cycles ago
//   test_mode      select internal colour bars (only with VGA_TEST_PATTERN_EN)
//   xcoor/ycoor    current h/v counter value
//   line_start     xcoor==0 (gated by enable)
//   frame_start    xcoor==0 && ycoor==0 (gated by enable)
//   hs/vs          sync outputs, asserted level HS_POL/VS_POL
//   display_active visible region, aligned with red/green/blue_out
//   red_out/green_out/blue_out  pixel data, zero outside the visible region
//
// Optional feature macro: VGA_TEST_PATTERN_EN (adds test_mode and colour bars).
//
// xcoor/ycoor lead hs/vs/display_active/RGB by PIPE+1 enabled cycles.
module vga_timing_core #(
  parameter int COLOR_W  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [COLOR_W-1:0] red_in,
  input  logic [COLOR_W-1:0] green_in,
  input  logic [COLOR_W-1:0] blue_in,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               test_mode,
`endif
  output logic [9:0]         xcoor,
  output logic [9:0]         ycoor,
  output logic               line_start,
  output logic               frame_start,
  output logic               hs,
  output logic               vs,
  output logic               display_active,
  output logic [COLOR_W-1:0] red_out,
  output logic [COLOR_W-1:0] green_out,
  output logic [COLOR_W-1:0] blue_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  // 11-bit compare constants so a sync window ending at 1024 still works
  localparam logic [10:0] H_ACT11 = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT11 = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  // delay-line word: {active, hs, vs, x}; x is needed to draw the bars
  localparam int DW = 13;

  // bar index 0..7 for a visible x position
  function automatic logic [2:0] bar_of(input logic [9:0] x);
    logic [2:0] b;
    b = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if ({1'b0, x} >= 11'(i * BAR_W)) b = 3'(i);
      else b = b;
    end
    return b;
  endfunction
`else
  localparam int DW = 3;
`endif

  logic [9:0]         h_q, h_d, v_q, v_d;
  logic               act_q, act_d, hs_q, hs_d, vs_q, vs_d;
  logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic [DW-1:0]      raw, dly_out;
  logic               raw_act, raw_hs, raw_vs;

  // counter next-state: h wraps every line, v advances on h wrap
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (enable) begin
      if (h_q == H_LAST) begin
        h_d = 10'd0;
        if (v_q == V_LAST) v_d = 10'd0;
        else v_d = v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
        v_d = v_q;
      end
    end else begin
      h_d = h_q;
      v_d = v_q;
    end
  end

  // raw timing decoded from the current counter position
  always_comb begin
    raw_act = ({1'b0, h_q} < H_ACT11) && ({1'b0, v_q} < V_ACT11);
    raw_hs  = ({1'b0, h_q} >= HS_BEG) && ({1'b0, h_q} < HS_END);
    raw_vs  = ({1'b0, v_q} >= VS_BEG) && ({1'b0, v_q} < VS_END);
`ifdef VGA_TEST_PATTERN_EN
    raw = {raw_act, raw_hs, raw_vs, h_q};
`else
    raw = {raw_act, raw_hs, raw_vs};
`endif
  end

  // PIPE-deep delay line matching the pixel generator latency
  generate
    if (PIPE == 0) begin : g_nodly
      assign dly_out = raw;
    end else begin : g_dly
      logic [DW-1:0] dly_q [PIPE];
      logic [DW-1:0] dly_d [PIPE];

      // shift by one stage on enabled cycles, otherwise hold
      always_comb begin
        for (int i = 0; i < PIPE; i++) dly_d[i] = dly_q[i];
        if (enable) begin
          dly_d[0] = raw;
          for (int i = 1; i < PIPE; i++) dly_d[i] = dly_q[i-1];
        end else begin
          for (int i = 0; i < PIPE; i++) dly_d[i] = dly_q[i];
        end
      end

      // delay-line registers, cleared to "blank, no sync" on reset
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < PIPE; i++) dly_q[i] <= '0;
        end else begin
          dly_q <= dly_d;
        end
      end

      assign dly_out = dly_q[PIPE-1];
    end
  endgenerate

  // output stage: polarity applied here, pixel sampled on the same edge
  always_comb begin
    act_d   = act_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    if (enable) begin
      act_d = dly_out[DW-1];
      hs_d  = dly_out[DW-2] ? HS_POL : ~HS_POL;
      vs_d  = dly_out[DW-3] ? VS_POL : ~VS_POL;
      if (dly_out[DW-1]) begin
`ifdef VGA_TEST_PATTERN_EN
        if (test_mode) begin
          red_d   = {COLOR_W{bar_of(dly_out[9:0])[2]}};
          green_d = {COLOR_W{bar_of(dly_out[9:0])[1]}};
          blue_d  = {COLOR_W{bar_of(dly_out[9:0])[0]}};
        end else begin
          red_d   = red_in;
          green_d = green_in;
          blue_d  = blue_in;
        end
`else
        red_d   = red_in;
        green_d = green_in;
        blue_d  = blue_in;
`endif
      end else begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
      end
    end else begin
      act_d   = act_q;
      hs_d    = hs_q;
      vs_d    = vs_q;
      red_d   = red_q;
      green_d = green_q;
      blue_d  = blue_q;
    end
  end

  // counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q     <= 10'd0;
      v_q     <= 10'd0;
      act_q   <= 1'b0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      act_q   <= act_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign xcoor          = h_q;
  assign ycoor          = v_q;
  assign line_start     = enable && (h_q == 10'd0);
  assign frame_start    = enable && (h_q == 10'd0) && (v_q == 10'd0);
  assign hs             = hs_q;
  assign vs             = vs_q;
  assign display_active = act_q;
  assign red_out        = red_q;
  assign green_out      = green_q;
  assign blue_out       = blue_q;

endmodule
